f_pc_unit: RTL and testbench
============================

Name: f_pc_unit

Overview:
- Fetch-stage state holder that consumes the next-PC value chosen by the fetch control logic.
- Holds the program counter and drives the instruction-memory address.
- Owns the F/D pipeline latch, applies stall and redirect (squash) rules, and exposes saturating stall/redirect event counters to the debug path.
- Sits between the next-PC selector, instruction memory (combinational read) and the decode stage.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- NOP_INSN, 32'd0, instruction word injected into F/D on squash or reset.
- CNT_W, 16, width of each event counter.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- pc_next  input  32  next PC from the fetch control selector (already muxed for jump/jr/branch/bex).
- redirect  input  1  high when pc_next is a taken control-transfer target resolved in execute (jump, jr, branch, bex).
- stall  input  1  hazard-unit stall request for F and D.
- imem_data  input  32  instruction word at imem_addr, same cycle.
- imem_addr  output  32  current PC (equals pc register).
- pc_increment  output  32  pc + 1, word addressed, wraps modulo 2^32; fed back to the selector.
- fd_insn  output  32  F/D latched instruction.
- fd_pc  output  32  PC of fd_insn.
- fd_pc_inc  output  32  fd_pc + 1.
- fd_valid  output  1  fd_insn is a real instruction (0 = bubble).
- dx_flush  output  1  combinational copy of redirect; tells D/X latch to bubble.
- stall_count  output  CNT_W  cycles with effective stall.
- redirect_count  output  CNT_W  cycles with redirect.

Behaviour:
- Reset (synchronous, wins over all other inputs) sets:
  - pc = RESET_PC.
  - fd_insn = NOP_INSN, fd_pc = 0, fd_pc_inc = 0, fd_valid = 0.
  - Both counters = 0.
  - Asserting reset mid-run discards all in-flight state on that edge.
- Effective stall: eff_stall = stall & ~redirect. Redirect always overrides stall.
- PC update per edge:
  - redirect -> pc <= pc_next.
  - eff_stall -> pc holds.
  - otherwise -> pc <= pc_next.
  - No arithmetic on pc_next. pc_increment = pc + 32'd1, carry discarded; 32'hFFFFFFFF wraps to 0.
- F/D latch per edge:
  - redirect -> fd_insn <= NOP_INSN, fd_valid <= 0; fd_pc and fd_pc_inc hold.
  - eff_stall -> all F/D fields hold.
  - otherwise -> fd_insn <= imem_data, fd_pc <= pc, fd_pc_inc <= pc + 1, fd_valid <= 1.
- Latency:
  - Instruction at PC X appears on fd_insn one edge after pc == X with no stall/redirect.
  - After a redirect edge, the first valid target instruction reaches F/D on the following edge, so exactly one F/D bubble per redirect.
- dx_flush: purely combinational = redirect; no register.
- Counters:
  - stall_count increments on each edge with eff_stall = 1; redirect_count increments on each edge with redirect = 1.
  - Both saturate at all-ones and never wrap.
  - Both are cleared only by reset.
- Simultaneous stall and redirect: behaves as redirect only. stall_count does not increment; redirect_count does.
- Back-to-back redirects: each one loads pc_next and keeps fd_valid = 0.
- Outputs are driven only from registers, except pc_increment (adder on pc) and dx_flush.

Decomposition:
- Shared package (processor-wide constants): NOP_INSN encoding, RESET_PC, word-address increment constant 1, CNT_W default. Any future fetch/decode blocks use the same constants.
- One natural sub-module: sat_counter (CNT_W-bit, synchronous reset, increment enable, saturate at max), instantiated twice.
- The F/D latch stays inline; it is a few registers sharing one enable/squash rule.

Test Plan:
- Reset then free-run: hold reset 2 cycles, release. Drive pc_next = pc_increment, imem_data = 32'hA000_0000 | addr.
  - Expect imem_addr 0,1,2,3 on successive cycles.
  - Expect fd_valid = 0 in the first cycle, then fd_insn = 32'hA0000000 / fd_pc = 0, then 32'hA0000001 / fd_pc = 1.
- Stall: at pc = 5 assert stall for 3 cycles.
  - Expect imem_addr = 5 and F/D fields frozen for 3 cycles; stall_count = 3.
  - Next cycle fd_pc = 5.
- Redirect: at pc = 8 pulse redirect with pc_next = 32'h40.
  - Expect dx_flush = 1 that cycle.
  - Next edge: pc = 32'h40, fd_valid = 0, fd_insn = NOP_INSN.
  - Following edge: fd_pc = 32'h40, fd_valid = 1; redirect_count = 1.
- Stall and redirect together: stall = 1, redirect = 1, pc_next = 32'h100.
  - Expect pc = 32'h100 and fd_valid = 0.
  - stall_count unchanged, redirect_count + 1.
- Wrap and saturation:
  - Redirect to 32'hFFFFFFFF, then free-run. Expect pc_increment = 0 and next pc = 0; fd_pc_inc = 0 when fd_pc = 32'hFFFFFFFF.
  - With CNT_W = 4, hold stall 20 cycles. Expect stall_count to stick at 4'hF.
- Reset mid-run: assert reset while stall = 1 and fd_valid = 1. Expect next-edge pc = RESET_PC, fd_valid = 0, counters = 0.

Source files
------------

// File: rtl/f_pc_unit_pkg.sv
// Processor-wide fetch constants and the F/D latch record shared by fetch/decode blocks.
package f_pc_unit_pkg;

    localparam logic [31:0] NOP_INSN_DEF = 32'd0;
    localparam logic [31:0] RESET_PC_DEF = 32'd0;
    localparam logic [31:0] PC_STEP      = 32'd1;
    localparam int          CNT_W_DEF    = 16;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] pc_inc;
        logic        valid;
    } fd_latch_t;

    // Word-addressed sequential successor; the carry out of bit 31 is dropped.
    function automatic logic [31:0] pc_plus_one(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/f_pc_unit_sat_counter.sv
// Event counter that sticks at all-ones; cleared only by reset.
module f_pc_unit_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count enabled events, holding at the maximum instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage PC register, F/D pipeline latch with stall/squash, and debug event counters.
module f_pc_unit
    import f_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEF,
    parameter int          CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      pc_next,
    input  logic             redirect,
    input  logic             stall,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_increment,
    output logic [31:0]      fd_insn,
    output logic [31:0]      fd_pc,
    output logic [31:0]      fd_pc_inc,
    output logic             fd_valid,
    output logic             dx_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] redirect_count
);

    logic [31:0] pc;
    fd_latch_t   fd;
    logic        eff_stall;

    // A taken redirect must never be held off by a hazard stall.
    assign eff_stall    = stall & ~redirect;
    assign pc_increment = pc_plus_one(pc);
    assign imem_addr    = pc;
    assign dx_flush     = redirect;

    // PC register: hold only on an effective stall; pc_next is already the chosen target.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (!eff_stall) begin
            pc <= pc_next;
        end
    end

    // F/D latch: squash to a bubble on redirect (pc fields kept), freeze on stall, else capture fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            fd.insn   <= NOP_INSN;
            fd.pc     <= 32'd0;
            fd.pc_inc <= 32'd0;
            fd.valid  <= 1'b0;
        end else if (redirect) begin
            fd.insn  <= NOP_INSN;
            fd.valid <= 1'b0;
        end else if (!eff_stall) begin
            fd.insn   <= imem_data;
            fd.pc     <= pc;
            fd.pc_inc <= pc_increment;
            fd.valid  <= 1'b1;
        end
    end

    assign fd_insn   = fd.insn;
    assign fd_pc     = fd.pc;
    assign fd_pc_inc = fd.pc_inc;
    assign fd_valid  = fd.valid;

    f_pc_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (eff_stall),
        .count (stall_count)
    );

    f_pc_unit_sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (redirect),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_f_pc_unit.sv
// Scoreboard bench for f_pc_unit: a reference model pushes the expected post-edge
// outputs each cycle, and each scenario task pops and compares them after the edge.
module tb_f_pc_unit;

    localparam int          CW  = 4;
    localparam logic [31:0] NOP = 32'd0;
    localparam logic [31:0] RPC = 32'd0;

    logic          clock = 1'b0;
    logic          reset, redirect, stall;
    logic [31:0]   pc_next, imem_data;
    logic [31:0]   imem_addr, pc_increment, fd_insn, fd_pc, fd_pc_inc;
    logic          fd_valid, dx_flush;
    logic [CW-1:0] stall_count, redirect_count;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   pc_inc;
        logic [31:0]   insn;
        logic [31:0]   fpc;
        logic [31:0]   fpc_inc;
        logic          valid;
        logic [CW-1:0] sc;
        logic [CW-1:0] rc;
    } snap_t;

    snap_t obs;
    snap_t exp_s;
    snap_t sb_q[$];
    int    tests_run = 0;
    int    fails     = 0;

    logic [31:0]   m_pc, m_insn, m_fpc, m_fpcinc;
    logic          m_valid;
    logic [CW-1:0] m_sc, m_rc;

    f_pc_unit #(.RESET_PC(RPC), .NOP_INSN(NOP), .CNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_next        (pc_next),
        .redirect       (redirect),
        .stall          (stall),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .pc_increment   (pc_increment),
        .fd_insn        (fd_insn),
        .fd_pc          (fd_pc),
        .fd_pc_inc      (fd_pc_inc),
        .fd_valid       (fd_valid),
        .dx_flush       (dx_flush),
        .stall_count    (stall_count),
        .redirect_count (redirect_count)
    );

    always #5 clock = ~clock;

    // Combinational instruction memory: tags each word with its address.
    assign imem_data = 32'hA000_0000 | imem_addr;
    assign obs = {imem_addr, pc_increment, fd_insn, fd_pc, fd_pc_inc, fd_valid, stall_count, redirect_count};

    // Advance the reference model over one edge, queue its expectation, then clock the DUT.
    task automatic cycle();
        logic  es;
        snap_t e;
        es = stall & ~redirect;
        if (reset) begin
            m_pc = RPC; m_insn = NOP; m_fpc = 32'd0; m_fpcinc = 32'd0;
            m_valid = 1'b0; m_sc = '0; m_rc = '0;
        end else begin
            if (redirect) begin
                m_insn = NOP; m_valid = 1'b0;
            end else if (!es) begin
                m_insn = 32'hA000_0000 | m_pc; m_fpc = m_pc; m_fpcinc = m_pc + 32'd1; m_valid = 1'b1;
            end
            if (!es) m_pc = pc_next;
            if (es && (m_sc != '1)) m_sc = m_sc + 1'b1;
            if (redirect && (m_rc != '1)) m_rc = m_rc + 1'b1;
        end
        e = {m_pc, m_pc + 32'd1, m_insn, m_fpc, m_fpcinc, m_valid, m_sc, m_rc};
        sb_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; pc_next = 32'h1234;
        for (int i = 0; i < 2; i++) begin
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL reset_sb: got %h want %h", obs, exp_s); end
        end
        reset = 1'b0;
        tests_run++;
        if (imem_addr !== RPC || fd_valid !== 1'b0 || fd_insn !== NOP) begin
            fails++; $display("FAIL reset_state: addr %h valid %b insn %h want %h 0 %h", imem_addr, fd_valid, fd_insn, RPC, NOP);
        end
    endtask

    task automatic test_free_run();
        for (int k = 1; k <= 3; k++) begin
            pc_next = m_pc + 32'd1;
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL free_run_sb: got %h want %h", obs, exp_s); end
            tests_run++;
            if (imem_addr !== 32'(k) || fd_pc !== 32'(k - 1) || fd_insn !== (32'hA000_0000 | 32'(k - 1)) || fd_valid !== 1'b1) begin
                fails++; $display("FAIL free_run_%0d: addr %h fd_pc %h insn %h valid %b", k, imem_addr, fd_pc, fd_insn, fd_valid);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8 && m_pc != 32'd5; i++) begin
            pc_next = m_pc + 32'd1;
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL stall_pre_sb: got %h want %h", obs, exp_s); end
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_next = 32'd6;
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL stall_sb: got %h want %h", obs, exp_s); end
            tests_run++;
            if (imem_addr !== 32'd5 || fd_pc !== 32'd4 || fd_insn !== 32'hA000_0004) begin
                fails++; $display("FAIL stall_hold: addr %h fd_pc %h insn %h want 5 4 a0000004", imem_addr, fd_pc, fd_insn);
            end
        end
        tests_run++;
        if (stall_count !== 4'd3) begin fails++; $display("FAIL stall_count: got %0d want 3", stall_count); end
        stall = 1'b0;
        pc_next = m_pc + 32'd1;
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (fd_pc !== 32'd5 || obs !== exp_s) begin fails++; $display("FAIL stall_release: fd_pc %h want 5; got %h want %h", fd_pc, obs, exp_s); end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 8 && m_pc != 32'd8; i++) begin
            pc_next = m_pc + 32'd1;
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL redir_pre_sb: got %h want %h", obs, exp_s); end
        end
        redirect = 1'b1; pc_next = 32'h40;
        #1;
        tests_run++;
        if (dx_flush !== 1'b1) begin fails++; $display("FAIL dx_flush_high: got %b want 1", dx_flush); end
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (imem_addr !== 32'h40 || fd_valid !== 1'b0 || fd_insn !== NOP || obs !== exp_s) begin
            fails++; $display("FAIL redir_edge: addr %h valid %b insn %h; got %h want %h", imem_addr, fd_valid, fd_insn, obs, exp_s);
        end
        redirect = 1'b0; pc_next = m_pc + 32'd1;
        #1;
        tests_run++;
        if (dx_flush !== 1'b0) begin fails++; $display("FAIL dx_flush_low: got %b want 0", dx_flush); end
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (fd_pc !== 32'h40 || fd_valid !== 1'b1 || redirect_count !== 4'd1 || obs !== exp_s) begin
            fails++; $display("FAIL redir_target: fd_pc %h valid %b rc %0d; got %h want %h", fd_pc, fd_valid, redirect_count, obs, exp_s);
        end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect = 1'b1; pc_next = 32'h100;
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (imem_addr !== 32'h100 || fd_valid !== 1'b0 || stall_count !== 4'd3 || redirect_count !== 4'd2 || obs !== exp_s) begin
            fails++; $display("FAIL stall_redirect: addr %h valid %b sc %0d rc %0d want 100 0 3 2", imem_addr, fd_valid, stall_count, redirect_count);
        end
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt [3];
        tgt[0] = 32'h200; tgt[1] = 32'h300; tgt[2] = 32'hFFFF_FFFF;
        redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_next = tgt[i];
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (imem_addr !== tgt[i] || fd_valid !== 1'b0 || obs !== exp_s) begin
                fails++; $display("FAIL b2b_%0d: addr %h valid %b; got %h want %h", i, imem_addr, fd_valid, obs, exp_s);
            end
        end
        redirect = 1'b0;
        tests_run++;
        if (pc_increment !== 32'd0) begin fails++; $display("FAIL wrap_inc: got %h want 0", pc_increment); end
        pc_next = m_pc + 32'd1;
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (imem_addr !== 32'd0 || fd_pc !== 32'hFFFF_FFFF || fd_pc_inc !== 32'd0 || fd_valid !== 1'b1 || obs !== exp_s) begin
            fails++; $display("FAIL wrap_fd: addr %h fd_pc %h fd_pc_inc %h valid %b", imem_addr, fd_pc, fd_pc_inc, fd_valid);
        end
    endtask

    task automatic test_saturation();
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_next = m_pc + 32'd1;
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL sat_stall_sb_%0d: got %h want %h", i, obs, exp_s); end
        end
        tests_run++;
        if (stall_count !== 4'hF) begin fails++; $display("FAIL sat_stall: got %h want f", stall_count); end
        stall = 1'b0; redirect = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc_next = 32'(i * 4 + 32'h800);
            cycle();
            exp_s = sb_q.pop_front();
            tests_run++;
            if (obs !== exp_s) begin fails++; $display("FAIL sat_redir_sb_%0d: got %h want %h", i, obs, exp_s); end
        end
        tests_run++;
        if (redirect_count !== 4'hF) begin fails++; $display("FAIL sat_redirect: got %h want f", redirect_count); end
        redirect = 1'b0;
    endtask

    task automatic test_reset_midrun();
        pc_next = m_pc + 32'd1;
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (fd_valid !== 1'b1 || obs !== exp_s) begin fails++; $display("FAIL midrun_pre: valid %b; got %h want %h", fd_valid, obs, exp_s); end
        stall = 1'b1; reset = 1'b1; pc_next = 32'h55;
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (imem_addr !== RPC || fd_valid !== 1'b0 || stall_count !== '0 || redirect_count !== '0 || obs !== exp_s) begin
            fails++; $display("FAIL midrun_reset: addr %h valid %b sc %h rc %h", imem_addr, fd_valid, stall_count, redirect_count);
        end
        stall = 1'b0; reset = 1'b0;
        pc_next = m_pc + 32'd1;
        cycle();
        exp_s = sb_q.pop_front();
        tests_run++;
        if (obs !== exp_s) begin fails++; $display("FAIL midrun_post_sb: got %h want %h", obs, exp_s); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; pc_next = 32'd0;
        m_pc = 32'd0; m_insn = 32'd0; m_fpc = 32'd0; m_fpcinc = 32'd0; m_valid = 1'b0; m_sc = '0; m_rc = '0;
        @(negedge clock);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_back_to_back();
        test_saturation();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
